regfile_sb: RTL and testbench
=============================

// Module: regfile_sb
// PURPOSE
//  Parametrised CPU register file: R registered read ports, one write port,
//  write-to-read bypass, optional hard-zero register 0.
//  Integrated scoreboard (per-register busy bit) tracks in-flight writes, so
//  decode can detect RAW/WAW hazards. Sits between decode (reads/issue) and
//  writeback (writes).
// PARAMETERS
//  N        32  data width of each register
//  M        3   address bits; 2**M registers
//  R        2   number of read ports (1..4)
//  ZERO_REG 1   1: reg 0 reads 0, ignores writes, never busy; 0: ordinary reg
// PORTS
//  clk         in   1      clock, all state on posedge
//  rst         in   1      asynchronous reset, active-high
//  rd_addr     in   R*M    read addresses; port k = [k*M +: M]
//  rd_data     out  R*N    read data, registered; port k = [k*N +: N]
//  rd_busy     out  R      registered busy bit of each addressed register
//  wr_en       in   1      writeback strobe
//  wr_addr     in   M      writeback register
//  wr_data     in   N      writeback value
//  iss_en      in   1      decode requests to reserve iss_addr as destination
//  iss_addr    in   M      destination to reserve
//  iss_ok      out  1      combinational: reservation accepted this cycle
//  busy_cnt    out  M+1    registered count of busy registers
// BEHAVIOUR
//  - Reset (async, rst=1): all regs 0, all busy 0, rd_data 0, rd_busy 0,
//    busy_cnt 0. Held while rst=1; first update on first posedge after release.
//  - Write: on posedge with wr_en=1, regs[wr_addr] <= wr_data and busy[wr_addr]
//    cleared; ignored entirely for addr 0 when ZERO_REG=1.
//  - Read latency 1: rd_data[k] at cycle t+1 = value of regs[rd_addr[k]] after
//    the cycle-t write, i.e. same-cycle write to the same address is bypassed
//    (new value returned). All R ports independent; equal addresses allowed.
//  - rd_busy[k] at t+1 = busy[rd_addr[k]] after the cycle-t update (same
//    post-update view as rd_data).
//  - iss_ok = iss_en & (~busy[iss_addr] | (wr_en & wr_addr==iss_addr));
//    with ZERO_REG=1 and iss_addr=0: iss_ok = iss_en, no bit set.
//  - On posedge with iss_ok=1, busy[iss_addr] <= 1. Rejected issue (busy,
//    no matching write) changes nothing; decode must stall and retry.
//  - Simultaneous issue and write to same reg: data written, busy ends SET
//    (new producer wins). Different regs: both take effect.
//  - Write to a non-busy reg is legal (plain write); busy stays 0.
//  - busy_cnt = popcount of busy after update; range 0..2**M (or 2**M-1 with
//    ZERO_REG=1); never wraps.
//  - Unknown/X addresses with enable low have no effect.
// STRUCTURE
//  - cpu_pkg: typedefs reg_addr_t (M bits), reg_data_t (N bits), constant
//    ZERO_ADDR; shared with decode and writeback stages.
//  - Sub-module sb_bits: busy vector, iss_ok logic, busy_cnt; regfile_sb
//    holds data array, bypass muxes and read registers.
//  - Read ports generated with a for-generate over R.
// TESTING
//  1 Reset mid-run: write 0xDEAD to r3, assert rst async mid-cycle ->
//    rd_data/rd_busy/busy_cnt 0 immediately; read r3 after release -> 0.
//  2 Bypass: same cycle wr r5=0x1234, rd_addr0=5, rd_addr1=5 -> next cycle
//    both ports 0x1234.
//  3 Zero reg: wr r0=0xFFFF_FFFF, iss r0 -> iss_ok=1, read r0=0, busy_cnt=0.
//  4 Hazard: iss r2 (ok), iss r2 again -> iss_ok=0; wr r2=7 with iss r2 same
//    cycle -> iss_ok=1, read r2=7, rd_busy=1, busy_cnt=1.
//  5 Fill: issue all 7 nonzero regs -> busy_cnt=7; write all back -> 0.
//  6 Params: R=3, M=2, ZERO_REG=0 -> r0 writable (wr 0x55 reads 0x55),
//    three distinct reads return correct values in one cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared register-file types for decode, regfile and writeback stages.
package cpu_pkg;

    localparam int unsigned CPU_N = 32;
    localparam int unsigned CPU_M = 3;

    typedef logic [CPU_M-1:0] reg_addr_t;
    typedef logic [CPU_N-1:0] reg_data_t;

    localparam reg_addr_t ZERO_ADDR = '0;

endpackage

// File: rtl/sb_bits.sv
// Scoreboard: one busy bit per register, issue acceptance and busy count.
module sb_bits
    import cpu_pkg::*;
#(
    parameter int unsigned M        = CPU_M,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_en,
    input  logic [M-1:0]      i_wr_addr,
    input  logic              i_iss_en,
    input  logic [M-1:0]      i_iss_addr,
    output logic              o_iss_ok,
    output logic [2**M-1:0]   o_busy_nxt,
    output logic [M:0]        o_busy_cnt
);

    localparam int unsigned NREG = 2**M;

    logic [NREG-1:0] r_busy;
    logic [M:0]      r_busy_cnt;
    logic [M:0]      w_cnt;
    logic            w_zero_iss;

    // A matching writeback frees the register in the same cycle it is re-reserved.
    assign w_zero_iss = ZERO_REG & (i_iss_addr == M'(ZERO_ADDR));
    assign o_iss_ok   = i_iss_en & (w_zero_iss | ~r_busy[i_iss_addr]
                                    | (i_wr_en & (i_wr_addr == i_iss_addr)));

    // Issue is applied after the write so a new producer keeps the bit set.
    always_comb begin
        o_busy_nxt = r_busy;
        if (i_wr_en) begin
            o_busy_nxt[i_wr_addr] = 1'b0;
        end
        if (o_iss_ok) begin
            o_busy_nxt[i_iss_addr] = 1'b1;
        end
        if (ZERO_REG) begin
            o_busy_nxt[0] = 1'b0;
        end
    end

    always_comb begin
        w_cnt = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            w_cnt = w_cnt + (M+1)'(o_busy_nxt[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy     <= '0;
            r_busy_cnt <= '0;
        end else begin
            r_busy     <= o_busy_nxt;
            r_busy_cnt <= w_cnt;
        end
    end

    assign o_busy_cnt = r_busy_cnt;

endmodule

// File: rtl/regfile_sb.sv
// Register file with R registered read ports, write bypass, optional hard-zero
// r0, and an integrated busy scoreboard for hazard detection at decode.
module regfile_sb
    import cpu_pkg::*;
#(
    parameter int unsigned N        = CPU_N,
    parameter int unsigned M        = CPU_M,
    parameter int unsigned R        = 2,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [R*M-1:0]  i_rd_addr,
    output logic [R*N-1:0]  o_rd_data,
    output logic [R-1:0]    o_rd_busy,
    input  logic            i_wr_en,
    input  logic [M-1:0]    i_wr_addr,
    input  logic [N-1:0]    i_wr_data,
    input  logic            i_iss_en,
    input  logic [M-1:0]    i_iss_addr,
    output logic            o_iss_ok,
    output logic [M:0]      o_busy_cnt
);

    localparam int unsigned NREG = 2**M;

    logic [N-1:0]    r_regs    [NREG];
    logic [N-1:0]    r_rd_data [R];
    logic [R-1:0]    r_rd_busy;
    logic [N-1:0]    w_rd_val  [R];
    logic [R-1:0]    w_rd_busy;
    logic [NREG-1:0] w_busy_nxt;
    logic            w_wr_ok;

    assign w_wr_ok = i_wr_en & ~(ZERO_REG & (i_wr_addr == M'(ZERO_ADDR)));

    sb_bits #(
        .M        (M),
        .ZERO_REG (ZERO_REG)
    ) u_sb_bits (
        .clk        (clk),
        .rst        (rst),
        .i_wr_en    (i_wr_en),
        .i_wr_addr  (i_wr_addr),
        .i_iss_en   (i_iss_en),
        .i_iss_addr (i_iss_addr),
        .o_iss_ok   (o_iss_ok),
        .o_busy_nxt (w_busy_nxt),
        .o_busy_cnt (o_busy_cnt)
    );

    // Each port sees the post-write view: same-cycle write data is forwarded.
    for (genvar k = 0; k < R; k++) begin : g_rd
        logic [M-1:0] w_addr;
        assign w_addr        = i_rd_addr[k*M +: M];
        assign w_rd_val[k]   = (w_wr_ok && (i_wr_addr == w_addr)) ? i_wr_data : r_regs[w_addr];
        assign w_rd_busy[k]  = w_busy_nxt[w_addr];
        assign o_rd_data[k*N +: N] = r_rd_data[k];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_regs[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < R; k++) begin
                r_rd_data[k] <= '0;
            end
            r_rd_busy <= '0;
        end else begin
            for (int unsigned k = 0; k < R; k++) begin
                r_rd_data[k] <= w_rd_val[k];
            end
            r_rd_busy <= w_rd_busy;
        end
    end

    assign o_rd_busy = r_rd_busy;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: default instance (M=3,R=2,ZERO_REG=1) and a small
// instance (M=2,R=3,ZERO_REG=0), each checked every cycle against an array model.
module tb_regfile_sb;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // instance a: defaults
    logic [5:0]  a_rd_addr;
    logic [63:0] a_rd_data;
    logic [1:0]  a_rd_busy;
    logic        a_wr_en;
    logic [2:0]  a_wr_addr;
    logic [31:0] a_wr_data;
    logic        a_iss_en;
    logic [2:0]  a_iss_addr;
    logic        a_iss_ok;
    logic [3:0]  a_busy_cnt;

    // instance b: M=2, R=3, ZERO_REG=0
    logic [5:0]  b_rd_addr;
    logic [95:0] b_rd_data;
    logic [2:0]  b_rd_busy;
    logic        b_wr_en;
    logic [1:0]  b_wr_addr;
    logic [31:0] b_wr_data;
    logic        b_iss_en;
    logic [1:0]  b_iss_addr;
    logic        b_iss_ok;
    logic [2:0]  b_busy_cnt;

    regfile_sb u_a (
        .clk        (clk),
        .rst        (rst),
        .i_rd_addr  (a_rd_addr),
        .o_rd_data  (a_rd_data),
        .o_rd_busy  (a_rd_busy),
        .i_wr_en    (a_wr_en),
        .i_wr_addr  (a_wr_addr),
        .i_wr_data  (a_wr_data),
        .i_iss_en   (a_iss_en),
        .i_iss_addr (a_iss_addr),
        .o_iss_ok   (a_iss_ok),
        .o_busy_cnt (a_busy_cnt)
    );

    regfile_sb #(
        .N        (32),
        .M        (2),
        .R        (3),
        .ZERO_REG (1'b0)
    ) u_b (
        .clk        (clk),
        .rst        (rst),
        .i_rd_addr  (b_rd_addr),
        .o_rd_data  (b_rd_data),
        .o_rd_busy  (b_rd_busy),
        .i_wr_en    (b_wr_en),
        .i_wr_addr  (b_wr_addr),
        .i_wr_data  (b_wr_data),
        .i_iss_en   (b_iss_en),
        .i_iss_addr (b_iss_addr),
        .o_iss_ok   (b_iss_ok),
        .o_busy_cnt (b_busy_cnt)
    );

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    // Model state, index 0 = instance a, 1 = instance b
    reg_data_t m_regs [2][8];
    bit        m_busy [2][8];
    reg_data_t m_rd   [2][3];
    bit        m_rb   [2][3];
    int        m_cnt  [2];

    function automatic bit zr(int i);
        return (i == 0);
    endfunction

    function automatic int nreg(int i);
        return (i == 0) ? 8 : 4;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic bit iss_ok_exp(int i, bit we, int wa, bit ie, int ia);
        return ie && ((zr(i) && ia == 0) || !m_busy[i][ia] || (we && wa == ia));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int r = 0; r < 8; r++) begin
                m_regs[i][r] = '0;
                m_busy[i][r] = 1'b0;
            end
            for (int k = 0; k < 3; k++) begin
                m_rd[i][k] = '0;
                m_rb[i][k] = 1'b0;
            end
            m_cnt[i] = 0;
        end
    endtask

    // One clock of the architectural rules: write, then reservation, then reads.
    task automatic step(int i, bit we, int wa, reg_data_t wd, bit ie, int ia,
                        int r0, int r1, int r2);
        bit ok;
        int ra [3];
        ok = iss_ok_exp(i, we, wa, ie, ia);
        if (we && !(zr(i) && wa == 0)) begin
            m_regs[i][wa] = wd;
            m_busy[i][wa] = 1'b0;
        end
        if (ok && !(zr(i) && ia == 0)) m_busy[i][ia] = 1'b1;
        ra[0] = r0; ra[1] = r1; ra[2] = r2;
        for (int k = 0; k < 3; k++) begin
            m_rd[i][k] = m_regs[i][ra[k]];
            m_rb[i][k] = m_busy[i][ra[k]];
        end
        m_cnt[i] = 0;
        for (int r = 0; r < nreg(i); r++) m_cnt[i] += int'(m_busy[i][r]);
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_reset();
        end else begin
            step(0, a_wr_en, int'(a_wr_addr), a_wr_data, a_iss_en, int'(a_iss_addr),
                 int'(a_rd_addr[2:0]), int'(a_rd_addr[5:3]), 0);
            step(1, b_wr_en, int'(b_wr_addr), b_wr_data, b_iss_en, int'(b_iss_addr),
                 int'(b_rd_addr[1:0]), int'(b_rd_addr[3:2]), int'(b_rd_addr[5:4]));
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("a_rd_data%0d", k), a_rd_data[k*32 +: 32], m_rd[0][k]);
                chk($sformatf("a_rd_busy%0d", k), 32'(a_rd_busy[k]), 32'(m_rb[0][k]));
            end
            chk("a_busy_cnt", 32'(a_busy_cnt), m_cnt[0]);
            chk("a_iss_ok", 32'(a_iss_ok),
                32'(iss_ok_exp(0, a_wr_en, int'(a_wr_addr), a_iss_en, int'(a_iss_addr))));
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("b_rd_data%0d", k), b_rd_data[k*32 +: 32], m_rd[1][k]);
                chk($sformatf("b_rd_busy%0d", k), 32'(b_rd_busy[k]), 32'(m_rb[1][k]));
            end
            chk("b_busy_cnt", 32'(b_busy_cnt), m_cnt[1]);
            chk("b_iss_ok", 32'(b_iss_ok),
                32'(iss_ok_exp(1, b_wr_en, int'(b_wr_addr), b_iss_en, int'(b_iss_addr))));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        a_wr_en  = 1'b0;
        a_iss_en = 1'b0;
        b_wr_en  = 1'b0;
        b_iss_en = 1'b0;
    endtask

    initial begin
        a_rd_addr = '0; a_wr_en = 1'b0; a_wr_addr = '0; a_wr_data = '0;
        a_iss_en = 1'b0; a_iss_addr = '0;
        b_rd_addr = '0; b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0;
        b_iss_en = 1'b0; b_iss_addr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        rst    = 1'b0;
        chk_on = 1'b1;
        chk("rst_a_cnt", 32'(a_busy_cnt), 32'd0);
        chk("rst_a_data", a_rd_data[31:0], 32'd0);

        // 1: asynchronous reset in the middle of a cycle
        a_wr_en = 1'b1; a_wr_addr = 3'd3; a_wr_data = 32'hDEAD;
        a_iss_en = 1'b1; a_iss_addr = 3'd4;
        a_rd_addr = {3'd4, 3'd3};
        tick();
        chk("t1_data_pre", a_rd_data[31:0], 32'hDEAD);
        chk("t1_busy_pre", 32'(a_rd_busy[1]), 32'd1);
        chk("t1_cnt_pre", 32'(a_busy_cnt), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t1_data_rst", a_rd_data[31:0], 32'd0);
        chk("t1_busy_rst", 32'(a_rd_busy), 32'd0);
        chk("t1_cnt_rst", 32'(a_busy_cnt), 32'd0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        a_rd_addr = {3'd3, 3'd3};
        tick();
        chk("t1_r3_after", a_rd_data[31:0], 32'd0);

        // 2: write bypass to both ports
        a_wr_en = 1'b1; a_wr_addr = 3'd5; a_wr_data = 32'h1234;
        a_rd_addr = {3'd5, 3'd5};
        tick();
        chk("t2_port0", a_rd_data[31:0], 32'h1234);
        chk("t2_port1", a_rd_data[63:32], 32'h1234);

        // 3: hard-zero register
        a_wr_en = 1'b1; a_wr_addr = 3'd0; a_wr_data = 32'hFFFF_FFFF;
        a_iss_en = 1'b1; a_iss_addr = 3'd0;
        a_rd_addr = {3'd0, 3'd0};
        #1;
        chk("t3_iss_ok", 32'(a_iss_ok), 32'd1);
        tick();
        chk("t3_r0", a_rd_data[31:0], 32'd0);
        chk("t3_r0_busy", 32'(a_rd_busy[0]), 32'd0);
        chk("t3_cnt", 32'(a_busy_cnt), 32'd0);

        // 4: RAW/WAW hazard on r2
        a_iss_en = 1'b1; a_iss_addr = 3'd2;
        #1;
        chk("t4_iss1", 32'(a_iss_ok), 32'd1);
        tick();
        a_iss_en = 1'b1; a_iss_addr = 3'd2;
        #1;
        chk("t4_iss2_rej", 32'(a_iss_ok), 32'd0);
        tick();
        a_wr_en = 1'b1; a_wr_addr = 3'd2; a_wr_data = 32'd7;
        a_iss_en = 1'b1; a_iss_addr = 3'd2;
        a_rd_addr = {3'd2, 3'd2};
        #1;
        chk("t4_iss3", 32'(a_iss_ok), 32'd1);
        tick();
        chk("t4_data", a_rd_data[31:0], 32'd7);
        chk("t4_busy", 32'(a_rd_busy[0]), 32'd1);
        chk("t4_cnt", 32'(a_busy_cnt), 32'd1);

        // 5: fill the scoreboard then drain it
        a_wr_en = 1'b1; a_wr_addr = 3'd2; a_wr_data = 32'd0;
        tick();
        chk("t5_cnt0", 32'(a_busy_cnt), 32'd0);
        for (int r = 1; r < 8; r++) begin
            a_iss_en = 1'b1; a_iss_addr = 3'(r);
            tick();
        end
        chk("t5_cnt7", 32'(a_busy_cnt), 32'd7);
        a_iss_en = 1'b1; a_iss_addr = 3'd7;
        #1;
        chk("t5_full_rej", 32'(a_iss_ok), 32'd0);
        for (int r = 1; r < 8; r++) begin
            a_wr_en = 1'b1; a_wr_addr = 3'(r); a_wr_data = 32'(r * 32'h11);
            a_rd_addr = {3'(r), 3'(r)};
            tick();
        end
        chk("t5_cnt_drain", 32'(a_busy_cnt), 32'd0);
        chk("t5_r7", a_rd_data[31:0], 32'h77);

        // 6: R=3, M=2, ordinary r0
        b_wr_en = 1'b1; b_wr_addr = 2'd0; b_wr_data = 32'h55;
        tick();
        b_rd_addr = {2'd0, 2'd0, 2'd0};
        tick();
        chk("t6_r0", b_rd_data[31:0], 32'h55);
        for (int r = 1; r < 4; r++) begin
            b_wr_en = 1'b1; b_wr_addr = 2'(r); b_wr_data = 32'(r * 32'h11);
            tick();
        end
        b_rd_addr = {2'd3, 2'd2, 2'd1};
        tick();
        chk("t6_p0", b_rd_data[31:0], 32'h11);
        chk("t6_p1", b_rd_data[63:32], 32'h22);
        chk("t6_p2", b_rd_data[95:64], 32'h33);
        for (int r = 0; r < 4; r++) begin
            b_iss_en = 1'b1; b_iss_addr = 2'(r);
            tick();
        end
        chk("t6_cnt4", 32'(b_busy_cnt), 32'd4);
        chk("t6_busy", 32'(b_rd_busy), 32'h7);
        for (int r = 0; r < 4; r++) begin
            b_wr_en = 1'b1; b_wr_addr = 2'(r); b_wr_data = 32'(r + 32'h100);
            tick();
        end
        chk("t6_cnt0", 32'(b_busy_cnt), 32'd0);

        // mixed traffic, checked only by the model
        for (int n = 0; n < 300; n++) begin
            a_wr_en   = 1'($urandom_range(0, 1));
            a_wr_addr = 3'($urandom_range(0, 7));
            a_wr_data = $urandom;
            a_iss_en  = 1'($urandom_range(0, 1));
            a_iss_addr = 3'($urandom_range(0, 7));
            a_rd_addr = 6'($urandom_range(0, 63));
            b_wr_en   = 1'($urandom_range(0, 1));
            b_wr_addr = 2'($urandom_range(0, 3));
            b_wr_data = $urandom;
            b_iss_en  = 1'($urandom_range(0, 1));
            b_iss_addr = 2'($urandom_range(0, 3));
            b_rd_addr = 6'($urandom_range(0, 63));
            tick();
        end
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
